// File: rtl/mem_wb_stage_if.sv
// MEM-side handshake and data-memory read return into the MEM->WB stage.
interface mem_wb_stage_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_flush;
    logic        mem_wreg;
    logic [4:0]  mem_wa;
    logic [31:0] mem_wd;
    logic        mem_load;
    logic [2:0]  mem_ld_type;
    logic [1:0]  mem_addr_lo;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    // Upstream side: MEM stage plus the data-memory read return.
    modport master (
        output mem_valid, mem_flush, mem_wreg, mem_wa, mem_wd,
               mem_load, mem_ld_type, mem_addr_lo, dm_rvalid, dm_rdata,
        input  mem_ready
    );

    // The writeback stage.
    modport slave (
        input  mem_valid, mem_flush, mem_wreg, mem_wa, mem_wd,
               mem_load, mem_ld_type, mem_addr_lo, dm_rvalid, dm_rdata,
        output mem_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: registers results, waits on late load data,
// extends load data and drives the register-file write port.
module mem_wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic           cpu_clk_50M,
    input  logic           cpu_rst_n,
    mem_wb_stage_if.slave  mem_if,
    output logic [4:0]     wb_wa,
    output logic [31:0]    wb_wd,
    output logic           wb_we,
    output logic           wb_stall_req,
    output logic           load_err,
    output logic [31:0]    retired
);
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W1 = CNT_W + 1;

    typedef enum logic {IDLE, WAIT_LOAD} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [4:0]       ld_wa;
    logic             ld_wreg;
    logic [2:0]       ld_type;
    logic [1:0]       ld_off;

    logic             accept;
    logic             timeout;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // Handshake and stall are pure functions of the state.
    assign mem_if.mem_ready = (state == IDLE);
    assign wb_stall_req     = (state == WAIT_LOAD);
    assign accept           = mem_if.mem_valid & mem_if.mem_ready & ~mem_if.mem_flush;

    // Abort on the cycle that would bring the wait count up to the limit.
    assign timeout = (CNT_W1'(wait_cnt) + CNT_W1'(1)) == CNT_W1'(LOAD_TIMEOUT);

    // Little-endian lane selection and sign/zero extension of load data.
    always_comb begin
        ld_byte = mem_if.dm_rdata[7:0];
        ld_half = ld_off[1] ? mem_if.dm_rdata[31:16] : mem_if.dm_rdata[15:0];
        ld_data = mem_if.dm_rdata;
        case (ld_off)
            2'd0:    ld_byte = mem_if.dm_rdata[7:0];
            2'd1:    ld_byte = mem_if.dm_rdata[15:8];
            2'd2:    ld_byte = mem_if.dm_rdata[23:16];
            default: ld_byte = mem_if.dm_rdata[31:24];
        endcase
        case (ld_type)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {24'd0, ld_byte};
            3'd2:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd3:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_if.dm_rdata;
        endcase
    end

    // Stage FSM, writeback registers, timeout counter and retire counter.
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ld_wa    <= '0;
            ld_wreg  <= 1'b0;
            ld_type  <= '0;
            ld_off   <= '0;
            wb_wa    <= '0;
            wb_wd    <= '0;
            wb_we    <= 1'b0;
            load_err <= 1'b0;
            retired  <= '0;
        end else begin
            wb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (mem_if.mem_load) begin
                            ld_wa    <= mem_if.mem_wa;
                            ld_wreg  <= mem_if.mem_wreg;
                            ld_type  <= mem_if.mem_ld_type;
                            ld_off   <= mem_if.mem_addr_lo;
                            wait_cnt <= '0;
                            state    <= WAIT_LOAD;
                        end else begin
                            wb_wa   <= mem_if.mem_wa;
                            wb_wd   <= mem_if.mem_wd;
                            wb_we   <= mem_if.mem_wreg & (mem_if.mem_wa != 5'd0);
                            retired <= retired + 32'd1;
                        end
                    end
                end
                WAIT_LOAD: begin
                    if (mem_if.dm_rvalid) begin
                        wb_wa   <= ld_wa;
                        wb_wd   <= ld_data;
                        wb_we   <= ld_wreg & (ld_wa != 5'd0);
                        retired <= retired + 32'd1;
                        state   <= IDLE;
                    end else if (timeout) begin
                        load_err <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases plus random transactions
// checked against a transaction-level model.
module tb_mem_wb_stage;
    localparam int unsigned TO = 4;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        wb_we;
    logic        wb_stall_req;
    logic        load_err;
    logic [31:0] retired;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.LOAD_TIMEOUT(TO)) dut (
        .cpu_clk_50M  (cpu_clk_50M),
        .cpu_rst_n    (cpu_rst_n),
        .mem_if       (bus.slave),
        .wb_wa        (wb_wa),
        .wb_wd        (wb_wd),
        .wb_we        (wb_we),
        .wb_stall_req (wb_stall_req),
        .load_err     (load_err),
        .retired      (retired)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_ret;
    logic        exp_err;

    // Count one comparison and report it if it differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    // Reference load extraction using shifts and masks.
    function automatic logic [31:0] extract(input logic [2:0] t, input logic [1:0] off,
                                            input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = (d >> (32'(off) * 32'd8)) & 32'h0000_00FF;
        h = (d >> (off[1] ? 32'd16 : 32'd0)) & 32'h0000_FFFF;
        case (t)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return b;
            3'd2:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return h;
            default: return d;
        endcase
    endfunction

    // Random payload on the MEM bus; validity is set by the caller.
    task automatic scramble();
        bus.mem_flush   = 1'($urandom);
        bus.mem_wreg    = 1'($urandom);
        bus.mem_wa      = 5'($urandom);
        bus.mem_wd      = $urandom;
        bus.mem_load    = 1'($urandom);
        bus.mem_ld_type = 3'($urandom);
        bus.mem_addr_lo = 2'($urandom);
        bus.dm_rdata    = $urandom;
    endtask

    task automatic idle_cycle(input logic stray_rvalid);
        scramble();
        bus.mem_valid = 1'b0;
        bus.dm_rvalid = stray_rvalid;
        tick();
        check("idle_we", 32'(wb_we), 32'd0);
        check("idle_retired", retired, exp_ret);
        check("idle_ready", 32'(bus.mem_ready), 32'd1);
        bus.dm_rvalid = 1'b0;
    endtask

    task automatic run_nonload(input logic valid, input logic flush, input logic wreg,
                               input logic [4:0] wa, input logic [31:0] wd);
        logic acc;
        scramble();
        bus.mem_valid = valid;
        bus.mem_flush = flush;
        bus.mem_load  = 1'b0;
        bus.mem_wreg  = wreg;
        bus.mem_wa    = wa;
        bus.mem_wd    = wd;
        bus.dm_rvalid = 1'($urandom);
        check("nl_ready", 32'(bus.mem_ready), 32'd1);
        tick();
        acc = valid & ~flush;
        if (acc) exp_ret = exp_ret + 32'd1;
        check("nl_we", 32'(wb_we), 32'(acc & wreg & (wa != 5'd0)));
        if (acc) begin
            check("nl_wa", 32'(wb_wa), 32'(wa));
            check("nl_wd", wb_wd, wd);
        end
        check("nl_retired", retired, exp_ret);
        bus.mem_valid = 1'b0;
        bus.dm_rvalid = 1'b0;
    endtask

    // delay = wait cycle (1-based) carrying dm_rvalid; beyond TO means none.
    task automatic run_load(input logic [2:0] t, input logic [1:0] off, input logic wreg,
                            input logic [4:0] wa, input logic [31:0] rdata, input int delay);
        logic done;
        logic hit;
        scramble();
        bus.mem_valid   = 1'b1;
        bus.mem_flush   = 1'b0;
        bus.mem_load    = 1'b1;
        bus.mem_ld_type = t;
        bus.mem_addr_lo = off;
        bus.mem_wreg    = wreg;
        bus.mem_wa      = wa;
        bus.dm_rvalid   = 1'b0;
        check("ld_ready_idle", 32'(bus.mem_ready), 32'd1);
        tick();
        check("ld_accept_we", 32'(wb_we), 32'd0);
        done = 1'b0;
        for (int k = 1; k <= int'(TO) && !done; k++) begin
            check("ld_stall", 32'(wb_stall_req), 32'd1);
            check("ld_ready_wait", 32'(bus.mem_ready), 32'd0);
            scramble();
            bus.mem_valid = 1'b1;
            hit = (k == delay);
            bus.dm_rvalid = hit;
            if (hit) bus.dm_rdata = rdata;
            tick();
            bus.mem_valid = 1'b0;
            bus.dm_rvalid = 1'b0;
            if (hit) begin
                done    = 1'b1;
                exp_ret = exp_ret + 32'd1;
                check("ld_we", 32'(wb_we), 32'(wreg & (wa != 5'd0)));
                check("ld_wa", 32'(wb_wa), 32'(wa));
                check("ld_wd", wb_wd, extract(t, off, rdata));
                check("ld_ready_after", 32'(bus.mem_ready), 32'd1);
            end else if (k == int'(TO)) begin
                done    = 1'b1;
                exp_err = 1'b1;
                check("to_we", 32'(wb_we), 32'd0);
                check("to_ready", 32'(bus.mem_ready), 32'd1);
            end else begin
                check("ld_wait_we", 32'(wb_we), 32'd0);
            end
        end
        check("ld_retired", retired, exp_ret);
        check("ld_err", 32'(load_err), 32'(exp_err));
    endtask

    initial begin
        bus.mem_valid = 1'b0;
        bus.dm_rvalid = 1'b0;
        scramble();
        exp_ret   = 32'd0;
        exp_err   = 1'b0;
        cpu_rst_n = 1'b0;
        tick();
        tick();
        check("rst_we", 32'(wb_we), 32'd0);
        check("rst_wa", 32'(wb_wa), 32'd0);
        check("rst_wd", wb_wd, 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_ready", 32'(bus.mem_ready), 32'd1);
        check("rst_stall", 32'(wb_stall_req), 32'd0);
        cpu_rst_n = 1'b1;
        idle_cycle(1'b0);

        // ADDU to $5, then an empty cycle.
        run_nonload(1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        idle_cycle(1'b0);

        // Byte/halfword extraction with rvalid three cycles after accept.
        run_load(3'd0, 2'd2, 1'b1, 5'd7, 32'h1280_5678, 3);
        run_load(3'd1, 2'd2, 1'b1, 5'd8, 32'h1280_5678, 3);
        run_load(3'd2, 2'd2, 1'b1, 5'd9, 32'h1280_5678, 3);
        run_load(3'd3, 2'd0, 1'b1, 5'd10, 32'h1280_5678, 3);

        // $0 destination and flushed instruction.
        run_nonload(1'b1, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        run_nonload(1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE_F00D);

        // Timeout, then a stray rvalid in IDLE.
        run_load(3'd4, 2'd0, 1'b1, 5'd3, 32'h5555_AAAA, 100);
        idle_cycle(1'b1);

        // Asynchronous reset in the middle of a load wait.
        scramble();
        bus.mem_valid = 1'b1;
        bus.mem_flush = 1'b0;
        bus.mem_load  = 1'b1;
        bus.mem_wreg  = 1'b1;
        bus.mem_wa    = 5'd12;
        tick();
        bus.mem_valid = 1'b0;
        tick();
        check("mid_stall", 32'(wb_stall_req), 32'd1);
        #3 cpu_rst_n = 1'b0;
        #1;
        exp_ret = 32'd0;
        exp_err = 1'b0;
        check("arst_wa", 32'(wb_wa), 32'd0);
        check("arst_wd", wb_wd, 32'd0);
        check("arst_err", 32'(load_err), 32'd0);
        check("arst_retired", retired, 32'd0);
        check("arst_ready", 32'(bus.mem_ready), 32'd1);
        check("arst_stall", 32'(wb_stall_req), 32'd0);
        tick();
        cpu_rst_n = 1'b1;
        idle_cycle(1'b1);

        // Ten back-to-back commits.
        for (int i = 0; i < 10; i++)
            run_nonload(1'b1, 1'b0, 1'b1, 5'(i + 1), $urandom);
        check("stream_retired", retired, 32'd10);

        // Retire counter wrap.
        bus.mem_valid = 1'b0;
        force dut.retired = 32'hFFFF_FFFF;
        tick();
        release dut.retired;
        exp_ret = 32'hFFFF_FFFF;
        check("wrap_pre", retired, exp_ret);
        run_nonload(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0042);
        check("wrap_zero", retired, 32'd0);

        // Random mix of non-loads, flushes, bubbles, loads and timeouts.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: run_nonload(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                               5'($urandom), $urandom);
                1: idle_cycle(1'($urandom));
                default: run_load(3'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
                                  $urandom, int'($urandom_range(1, TO + 2)));
            endcase
        end
        check("final_retired", retired, exp_ret);
        check("final_err", 32'(load_err), 32'(exp_err));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM→WB pipeline stage of the five-stage MIPS core.
- Registers the memory-stage result and waits for data-memory load responses, which may arrive several cycles late.
- Extracts and extends byte, halfword and word load data.
- Drives the register file write port (write address, write data, write enable) and raises a pipeline stall request while a load is outstanding.

Parameters:
LOAD_TIMEOUT, 255, maximum cycles to wait in WAIT_LOAD for dm_rvalid before aborting (1..65535)

Ports:
cpu_clk_50M  input  1  core clock
cpu_rst_n  input  1  reset; asynchronous, active-low
mem_valid  input  1  MEM stage presents an instruction
mem_ready  output  1  stage accepts the instruction this cycle
mem_flush  input  1  kill the instruction presented this cycle
mem_wreg  input  1  instruction writes a GPR
mem_wa  input  5  destination register
mem_wd  input  32  ALU/non-load result
mem_load  input  1  instruction is a load
mem_ld_type  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW; 5-7 treated as LW
mem_addr_lo  input  2  load address bits [1:0]
dm_rvalid  input  1  data memory read data valid
dm_rdata  input  32  data memory read data
wb_wa  output  5  regfile write address
wb_wd  output  32  regfile write data
wb_we  output  1  regfile write enable, one cycle per commit
wb_stall_req  output  1  hold IF/ID/EX/MEM
load_err  output  1  sticky load-timeout flag
retired  output  32  count of committed instructions

Behaviour:
- Reset (asynchronous, cpu_rst_n=0):
  - state=IDLE; wb_wa=0, wb_wd=0, wb_we=0, load_err=0, retired=0, timeout counter=0.
  - Takes effect immediately, including mid-load; a later dm_rvalid is ignored.
- States: IDLE, WAIT_LOAD.
- Combinational outputs: mem_ready=(state==IDLE); wb_stall_req=(state==WAIT_LOAD).
- Accept = mem_valid & mem_ready & ~mem_flush. A flushed or absent instruction leaves wb_we=0 the next cycle and does not increment retired.
- IDLE, accept of a non-load:
  - Next edge: wb_wa=mem_wa, wb_wd=mem_wd, wb_we=mem_wreg & (mem_wa!=0).
  - retired += 1.
  - Back-to-back non-loads commit one per cycle.
- IDLE, accept of a load:
  - Latch wa, wreg, ld_type and addr_lo; go to WAIT_LOAD; wb_we=0.
  - Counter cleared to 0.
- IDLE without accept: wb_we=0 next edge; wb_wa/wb_wd hold. dm_rvalid in IDLE is ignored.
- WAIT_LOAD:
  - mem_flush and mem_valid are ignored; a load already in WB is never killed.
  - Counter increments each cycle without dm_rvalid.
- WAIT_LOAD, dm_rvalid=1 (cycle M):
  - Next edge: wb_wd = extracted data, wb_wa = latched wa, wb_we = wreg & (wa!=0), retired += 1, state=IDLE.
  - Commit appears at M+1; mem_ready=1 at M+1.
- WAIT_LOAD timeout:
  - Condition: counter reaches LOAD_TIMEOUT with dm_rvalid=0.
  - Set load_err (cleared only by reset); wb_we=0; retired unchanged; state=IDLE.
  - dm_rvalid in the same cycle as the timeout takes priority: normal commit.
- Load extraction (little-endian, off=addr_lo):
  - LB/LBU: byte = dm_rdata[8*off+7 : 8*off], sign- or zero-extended.
  - LH/LHU: half = off[1] ? dm_rdata[31:16] : dm_rdata[15:0]; off[0] ignored (alignment faults handled upstream).
  - LW and codes 5-7: dm_rdata, offset ignored.
- Writes to $0: wb_we is forced to 0 whenever the write address is 0.
- Counter: retired is 32-bit and wraps 0xFFFFFFFF→0.
- Writeback is same-cycle with regfile bypass: wb_* are registered outputs, stable for the whole commit cycle.

Test Plan:
- Reset, then ADDU result 0x0000_1234 to $5 at cycle 0 → cycle 1: wb_we=1, wb_wa=5, wb_wd=0x1234; cycle 2: wb_we=0; retired=1.
- Load LB, off=2, dm_rdata=0x12_80_56_78, dm_rvalid three cycles after accept → wb_stall_req=1 for 3 cycles, mem_ready=0; commit wb_wd=0xFFFFFF80 one cycle after rvalid. Repeat with LBU → 0x00000080; LH off=2 → 0x00001280; LHU off=0 → 0x00005678.
- Non-load targeting $0 with wreg=1 → wb_we stays 0; retired still increments. Same instruction with mem_flush=1 → no commit, retired unchanged.
- Load with no dm_rvalid, LOAD_TIMEOUT=4 → after 4 WAIT cycles load_err=1, wb_we never asserts, mem_ready=1 again; a stray dm_rvalid afterwards causes no write.
- Assert cpu_rst_n=0 asynchronously mid-WAIT_LOAD → outputs zero immediately, state IDLE; dm_rvalid after release ignored.
- Stream of 10 back-to-back non-loads → 10 consecutive wb_we cycles, retired=10; preload retired to 0xFFFFFFFF via 2^32-1 commits (or force) → next commit wraps to 0.
